pipelined_adder: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor; the next generation of the team's 1-bit full-adder cell.
- Splits a WIDTH-bit add into STAGES chunks, each a registered ripple-carry slice, and passes the carry between stages.
- Accepts one operation per cycle under a valid/ready handshake and returns sum, carry-out and signed overflow after STAGES cycles.
- Used as the arithmetic datapath primitive in wider ALU and accumulator blocks.

---
 rtl/pipelined_adder_if.sv | 16 +
 rtl/pipelined_adder.sv | 69 ++++++
 tb/tb_pipelined_adder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operation/result valid-ready bundle for pipelined_adder
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic in_valid, in_ready, cin, sub;
  logic out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: valid/ready pipelined adder/subtractor, one CHUNK-bit ripple slice per stage
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  pipelined_adder_if.slave io
);
  localparam int CHUNK = WIDTH / STAGES;
  logic advance;
  logic [WIDTH-1:0] bp;
  assign bp = io.sub ? ~io.b : io.b;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // operands shrink as they travel: only the not-yet-added upper bits are carried forward
    localparam int HI = WIDTH - k * CHUNK;
    logic [HI-1:0] ai, bi;
    logic ci, vi;
    logic [CHUNK:0] part;
    logic [(k+1)*CHUNK-1:0] s_nxt, s;
    logic v, c;
    assign part = {1'b0, ai[CHUNK-1:0]} + {1'b0, bi[CHUNK-1:0]} + {{CHUNK{1'b0}}, ci};
    if (k == 0) begin : g_in
      assign ai = io.a;
      assign bi = bp;
      assign ci = io.cin;
      assign vi = io.in_valid;
      assign s_nxt = part[CHUNK-1:0];
    end else begin : g_in
      assign ai = g_stage[k-1].g_hi.ar;
      assign bi = g_stage[k-1].g_hi.br;
      assign ci = g_stage[k-1].c;
      assign vi = g_stage[k-1].v;
      assign s_nxt = {part[CHUNK-1:0], g_stage[k-1].s};
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v <= 1'b0;
        c <= 1'b0;
        s <= '0;
      end else if (advance) begin
        v <= vi;
        c <= part[CHUNK];
        s <= s_nxt;
      end
    if (k < STAGES - 1) begin : g_hi
      logic [HI-CHUNK-1:0] ar, br;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          ar <= '0;
          br <= '0;
        end else if (advance) begin
          ar <= ai[HI-1:CHUNK];
          br <= bi[HI-1:CHUNK];
        end
    end else begin : g_ovf
      logic o;
      always_ff @(posedge clk or posedge rst)
        if (rst) o <= 1'b0;
        else if (advance) o <= (ai[HI-1] == bi[HI-1]) && (part[CHUNK-1] != ai[HI-1]);
    end
  end
  assign advance = !g_stage[STAGES-1].v || io.out_ready;
  assign io.in_ready = !rst && advance;
  assign io.out_valid = g_stage[STAGES-1].v;
  assign io.sum = g_stage[STAGES-1].s;
  assign io.cout = g_stage[STAGES-1].c;
  assign io.ovf = g_stage[STAGES-1].g_ovf.o;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against an arithmetic model
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8)) m ();
  pipelined_adder_if #(.WIDTH(4)) f1 ();
  pipelined_adder_if #(.WIDTH(4)) f2 ();
  pipelined_adder_if #(.WIDTH(4)) f4 ();
  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (.clk(clk), .rst(rst), .io(m.slave));
  pipelined_adder #(.WIDTH(4), .STAGES(1)) u1 (.clk(clk), .rst(rst), .io(f1.slave));
  pipelined_adder #(.WIDTH(4), .STAGES(2)) u2 (.clk(clk), .rst(rst), .io(f2.slave));
  pipelined_adder #(.WIDTH(4), .STAGES(4)) u4 (.clk(clk), .rst(rst), .io(f4.slave));

  logic [9:0] mo;
  logic vo[3];
  logic ir[3];
  logic [5:0] ro[3];
  assign mo = {m.ovf, m.cout, m.sum};
  assign vo[0] = f1.out_valid;
  assign vo[1] = f2.out_valid;
  assign vo[2] = f4.out_valid;
  assign ir[0] = f1.in_ready;
  assign ir[1] = f2.in_ready;
  assign ir[2] = f4.in_ready;
  assign ro[0] = {f1.ovf, f1.cout, f1.sum};
  assign ro[1] = {f2.ovf, f2.cout, f2.sum};
  assign ro[2] = {f4.ovf, f4.cout, f4.sum};

  // returns {ovf, cout, sum}: unsigned sum for cout, signed range test for ovf
  function automatic int model(input int w, input int a, input int b, input int ci, input int sb);
    int mask = (1 << w) - 1;
    int bp = (sb != 0) ? (~b & mask) : b;
    int t = a + bp + ci;
    int sa = (a > (mask >> 1)) ? a - (mask + 1) : a;
    int sbv = (bp > (mask >> 1)) ? bp - (mask + 1) : bp;
    int st = sa + sbv + ci;
    int ov = (st > (mask >> 1) || st < -((mask >> 1) + 1)) ? 1 : 0;
    return (t & ((mask << 1) | 1)) | (ov << (w + 1));
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", m.out_valid); end
    checks++;
    if (mo !== 10'h000) begin errors++; $display("FAIL reset_outputs got=%h want=000", mo); end
    checks++;
    if (m.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", m.in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", m.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    m.a = 8'h0F; m.b = 8'h01; m.cin = 1'b0; m.sub = 1'b0; m.in_valid = 1'b1; m.out_ready = 1'b1;
    #1;
    checks++;
    if (m.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b want=1", m.in_ready); end
    @(posedge clk);
    @(negedge clk);
    m.in_valid = 1'b0;
    checks++;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b want=0", m.out_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b want=1", m.out_valid); end
    checks++;
    if (mo !== 10'h010) begin errors++; $display("FAIL basic_result got=%h want=010", mo); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[6] = '{8'hFF, 8'h7F, 8'h0F, 8'h05, 8'h80, 8'h09};
    logic [7:0] tb[6] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h01, 8'h09};
    logic tc[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] te[6] = '{10'h100, 10'h280, 10'h010, 10'h0FE, 10'h37F, 10'h100};
    m.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        checks++;
        if (m.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got=%b want=0", m.out_valid); end
      end
      if (i >= 2) begin
        checks++;
        if (m.out_valid !== 1'b1 || mo !== te[i-2])
          begin errors++; $display("FAIL b2b_op%0d got=%b/%h want=1/%h", i - 2, m.out_valid, mo, te[i-2]); end
      end
      if (i < 6) begin
        m.a = ta[i]; m.b = tb[i]; m.cin = tc[i]; m.sub = ts[i]; m.in_valid = 1'b1;
      end else m.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int q[$];
    int sent = 0;
    bit hold = 1'b0;
    int av = 0, bv = 0, cv = 0, sv = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      m.out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 8) begin
        if (!hold) begin
          av = int'($urandom_range(0, 255)); bv = int'($urandom_range(0, 255));
          cv = int'($urandom_range(0, 1)); sv = int'($urandom_range(0, 1));
          m.a = 8'(av); m.b = 8'(bv); m.cin = 1'(cv); m.sub = 1'(sv);
        end
        m.in_valid = 1'b1;
      end else m.in_valid = 1'b0;
      #1;
      if (cyc >= 2) begin
        checks++;
        if (m.out_valid !== (q.size() != 0))
          begin errors++; $display("FAIL stall_valid cyc=%0d got=%b want=%b", cyc, m.out_valid, q.size() != 0); end
      end
      if (m.out_valid && q.size() != 0) begin
        checks++;
        if (mo !== 10'(q[0])) begin errors++; $display("FAIL stall_data cyc=%0d got=%h want=%h", cyc, mo, 10'(q[0])); end
        if (m.out_ready) void'(q.pop_front());
      end
      if (!m.out_ready && m.out_valid) begin
        checks++;
        if (m.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, m.in_ready); end
      end
      if (m.in_valid && m.in_ready) begin
        q.push_back(model(8, av, bv, cv, sv));
        sent++;
        hold = 1'b0;
      end else hold = m.in_valid;
      @(posedge clk);
      @(negedge clk);
    end
    m.out_ready = 1'b1;
    checks++;
    if (q.size() != 0 || sent != 8) begin errors++; $display("FAIL stall_drain got=%0d/%0d want=0/8", q.size(), sent); end
  endtask

  task automatic test_exhaustive();
    int exp4[1024];
    int rc[3] = '{0, 0, 0};
    int idx = 0;
    int cyc = 0;
    logic iv;
    f1.out_ready = 1'b1; f2.out_ready = 1'b1; f4.out_ready = 1'b1;
    while ((idx < 1024 || rc[0] < 1024 || rc[1] < 1024 || rc[2] < 1024) && cyc < 8000) begin
      for (int k = 0; k < 3; k++)
        if (vo[k]) begin
          checks++;
          if (rc[k] >= idx) begin errors++; $display("FAIL exh_extra dut=%0d got=%h want=none", k, ro[k]); end
          else begin
            if (ro[k] !== 6'(exp4[rc[k]]))
              begin errors++; $display("FAIL exh_data dut=%0d n=%0d got=%h want=%h", k, rc[k], ro[k], 6'(exp4[rc[k]])); end
            rc[k]++;
          end
        end
      iv = idx < 1024 && $urandom_range(0, 3) != 0;
      f1.in_valid = iv; f1.a = 4'(idx >> 4); f1.b = 4'(idx); f1.cin = 1'(idx >> 8); f1.sub = 1'(idx >> 9);
      f2.in_valid = iv; f2.a = 4'(idx >> 4); f2.b = 4'(idx); f2.cin = 1'(idx >> 8); f2.sub = 1'(idx >> 9);
      f4.in_valid = iv; f4.a = 4'(idx >> 4); f4.b = 4'(idx); f4.cin = 1'(idx >> 8); f4.sub = 1'(idx >> 9);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ir[k] !== 1'b1) begin errors++; $display("FAIL exh_in_ready dut=%0d got=%b want=1", k, ir[k]); end
      end
      if (iv) begin
        exp4[idx] = model(4, (idx >> 4) & 15, idx & 15, (idx >> 8) & 1, (idx >> 9) & 1);
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    f1.in_valid = 1'b0; f2.in_valid = 1'b0; f4.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rc[k] != 1024) begin errors++; $display("FAIL exh_count dut=%0d got=%0d want=1024", k, rc[k]); end
    end
  endtask

  task automatic test_async_reset();
    m.out_ready = 1'b1;
    m.a = 8'h12; m.b = 8'h34; m.cin = 1'b0; m.sub = 1'b0; m.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m.a = 8'hA0; m.b = 8'h01; m.cin = 1'b1; m.sub = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m.out_valid !== 1'b1 || mo !== 10'h046) begin errors++; $display("FAIL rst_inflight got=%b/%h want=1/046", m.out_valid, mo); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b want=0", m.out_valid); end
    checks++;
    if (mo !== 10'h000) begin errors++; $display("FAIL rst_async_outputs got=%h want=000", mo); end
    checks++;
    if (m.in_ready !== 1'b0) begin errors++; $display("FAIL rst_async_in_ready got=%b want=0", m.in_ready); end
    @(negedge clk);
    m.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m.out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cyc=%0d got=%b want=0", i, m.out_valid); end
    end
    m.a = 8'h33; m.b = 8'h44; m.cin = 1'b0; m.sub = 1'b0; m.in_valid = 1'b1;
    #1;
    checks++;
    if (m.in_ready !== 1'b1) begin errors++; $display("FAIL rst_new_in_ready got=%b want=1", m.in_ready); end
    @(posedge clk);
    @(negedge clk);
    m.in_valid = 1'b0;
    checks++;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL rst_new_early got=%b want=0", m.out_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m.out_valid !== 1'b1 || mo !== 10'h077) begin errors++; $display("FAIL rst_new_result got=%b/%h want=1/077", m.out_valid, mo); end
  endtask

  initial begin
    m.in_valid = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0; m.out_ready = 1'b1;
    f1.in_valid = 1'b0; f1.a = '0; f1.b = '0; f1.cin = 1'b0; f1.sub = 1'b0; f1.out_ready = 1'b1;
    f2.in_valid = 1'b0; f2.a = '0; f2.b = '0; f2.cin = 1'b0; f2.sub = 1'b0; f2.out_ready = 1'b1;
    f4.in_valid = 1'b0; f4.a = '0; f4.b = '0; f4.cin = 1'b0; f4.sub = 1'b0; f4.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_exhaustive();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
